batrider_pal_wr: RTL

- Writer end of the palette RAM port used by the colour output path.
- Copies the palette image from source memory (SDRAM shadow of the CPU palette area) into the 2048x16 palette BRAM during vertical blank, so the pixel-rate reader never sees a half-updated palette mid-frame.
- Transfer is armed by a CPU "palette dirty" pulse and runs once per armed vblank.
- Word format is xBGR555, passed through unmodified: bit15 ignored, 14:10 B, 9:5 G, 4:0 R.

---
 rtl/batrider_pal_pkg.sv | 29 ++
 rtl/batrider_pal_wr_edge.sv | 31 +++
 rtl/batrider_pal_wr.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/batrider_pal_pkg.sv
// ============================================================================
// Module   : batrider_pal_pkg
// Brief    : Shared palette constants, FSM state encoding and xBGR555 masks.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package batrider_pal_pkg;

    localparam int PAL_AW    = 11;
    localparam int PAL_WORDS = 2048;

    typedef logic [2:0] pal_wr_state_t;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] REQ     = 3'd1;
    localparam logic [2:0] WAIT    = 3'd2;
    localparam logic [2:0] WRITE   = 3'd3;
    localparam logic [2:0] DONE_ST = 3'd4;

    // xBGR555 field masks; bit 15 is don't-care.
    localparam logic [15:0] PAL_R_MASK = 16'h001F;
    localparam logic [15:0] PAL_G_MASK = 16'h03E0;
    localparam logic [15:0] PAL_B_MASK = 16'h7C00;

endpackage

`default_nettype wire

// File: rtl/batrider_pal_wr_edge.sv
// ============================================================================
// Module   : batrider_pal_wr_edge
// Brief    : Registered falling-edge detector for the active-low LVBL strobe.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module batrider_pal_wr_edge (
    input  logic clk,
    input  logic rst,
    input  logic lvbl,
    output logic fall
);

    logic prev;

    // prev resets low so a blank already in progress at reset release is not seen as a new one
    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= 1'b0;
            fall <= 1'b0;
        end else begin
            prev <= lvbl;
            fall <= prev & ~lvbl;
        end
    end

endmodule

`default_nettype wire

// File: rtl/batrider_pal_wr.sv
// ============================================================================
// Module   : batrider_pal_wr
// Brief    : Copies the palette image from source memory into palette BRAM
//            during vertical blank, once per armed vblank.
//            Optional checksum output: define BATRIDER_PAL_WR_CHKSUM_EN.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module batrider_pal_wr
    import batrider_pal_pkg::*;
#(
    parameter int                AW       = PAL_AW,
    parameter int                SRC_AW   = 22,
    parameter logic [SRC_AW-1:0] SRC_BASE = '0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              LVBL,
    input  logic              PAL_DIRTY,
    output logic              SRC_CS,
    output logic [SRC_AW-1:0] SRC_ADDR,
    input  logic              SRC_OK,
    input  logic [15:0]       SRC_DATA,
    output logic              PAL_WE,
    output logic [AW-1:0]     PAL_WADDR,
    output logic [15:0]       PAL_WDATA,
    output logic              BUSY,
    output logic              DONE
`ifdef BATRIDER_PAL_WR_CHKSUM_EN
    ,
    output logic [15:0]       CHKSUM
`endif
);

    pal_wr_state_t   state;
    logic [AW-1:0]   idx;
    logic            pending;
    logic            vb_start;

`ifdef BATRIDER_PAL_WR_CHKSUM_EN
    logic [15:0]     acc;
`endif

    batrider_pal_wr_edge u_edge (
        .clk  (CLK),
        .rst  (RESET),
        .lvbl (LVBL),
        .fall (vb_start)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            idx       <= '0;
            pending   <= 1'b0;
            SRC_CS    <= 1'b0;
            SRC_ADDR  <= '0;
            PAL_WE    <= 1'b0;
            PAL_WADDR <= '0;
            PAL_WDATA <= '0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
`ifdef BATRIDER_PAL_WR_CHKSUM_EN
            acc       <= '0;
            CHKSUM    <= '0;
`endif
        end else begin
            PAL_WE <= 1'b0;
            DONE   <= 1'b0;
            if (PAL_DIRTY) begin
                pending <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (vb_start && pending) begin
                        idx   <= '0;
                        BUSY  <= 1'b1;
                        state <= REQ;
`ifdef BATRIDER_PAL_WR_CHKSUM_EN
                        acc   <= '0;
`endif
                    end
                end

                REQ: begin
                    if (LVBL) begin
                        BUSY  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        SRC_CS   <= 1'b1;
                        SRC_ADDR <= SRC_BASE + SRC_AW'(idx);
                        state    <= WAIT;
                    end
                end

                // Leaving blank beats a simultaneous SRC_OK: nothing is written.
                WAIT: begin
                    if (LVBL) begin
                        SRC_CS <= 1'b0;
                        BUSY   <= 1'b0;
                        state  <= IDLE;
                    end else if (SRC_OK) begin
                        SRC_CS    <= 1'b0;
                        PAL_WE    <= 1'b1;
                        PAL_WADDR <= idx;
                        PAL_WDATA <= SRC_DATA;
                        state     <= WRITE;
`ifdef BATRIDER_PAL_WR_CHKSUM_EN
                        acc       <= acc + SRC_DATA;
`endif
                    end
                end

                WRITE: begin
                    if (&idx) begin
                        DONE    <= 1'b1;
                        pending <= PAL_DIRTY;
                        state   <= DONE_ST;
`ifdef BATRIDER_PAL_WR_CHKSUM_EN
                        CHKSUM  <= acc;
`endif
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= REQ;
                    end
                end

                DONE_ST: begin
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    SRC_CS <= 1'b0;
                    BUSY   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
